fpadd_arbiter: RTL
==================

// Module: fpadd_arbiter
// PURPOSE
//  Round-robin sequencer sharing one combinational double_adder among NREQ requesters.
//  Accepts one operand pair at a time and holds it on the adder for EXEC_CYCLES cycles.
//  The adder path is treated as a multicycle path; the result is registered and returned to the winner.
//  Sits between the FP issue logic (requesters) and the double_adder instance.
// PARAMETERS
//  NREQ         2   number of requesters (>=2)
//  EXEC_CYCLES  1   cycles operands are held before result capture (values <1 behave as 1)
// PORTS
//  clk         in   1         clock, all state on rising edge
//  reset       in   1         synchronous reset, active-low (0 = reset)
//  req_valid   in   NREQ      request valid, one bit per requester
//  req_ready   out  NREQ      request accepted (one-hot or 0)
//  req_srcA    in   NREQ*64   operand A; requester i on bits [64*i+63:64*i]
//  req_srcB    in   NREQ*64   operand B, same packing
//  rsp_valid   out  NREQ      result valid for the granted requester (one-hot or 0)
//  rsp_ready   in   NREQ      requester takes result
//  rsp_result  out  64        registered sum
//  add_srcA    out  64        to double_adder srcA (registered)
//  add_srcB    out  64        to double_adder srcB (registered)
//  add_result  in   64        from double_adder result
//  busy        out  1         1 when state != IDLE
//  perf_ops    out  32        completed-operation count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0 at edge)
//   - state=IDLE, all outputs 0, opA/opB/res regs 0, cnt=0.
//   - last_grant=NREQ-1, so requester 0 has first priority.
//   - Applies in any state; an in-flight op is dropped and no response is issued.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE
//   - Winner g = first i with req_valid[i], searching last_grant+1, +2, ... modulo NREQ.
//   - req_ready[g]=1 combinationally; all other req_ready bits are 0.
//   - Accept edge: opA<=srcA[g], opB<=srcB[g], gnt<=g, cnt<=EXEC_CYCLES-1; next state EXEC.
//   - No req_valid: stay IDLE. req_valid may drop without handshake; no penalty.
//  EXEC
//   - add_srcA/B = opA/opB, stable for the whole op.
//   - If cnt!=0: cnt<=cnt-1.
//   - If cnt==0: res<=add_result; next state RESP.
//   - cnt width = $clog2(EXEC_CYCLES+1).
//  RESP
//   - rsp_valid[gnt]=1, rsp_result=res.
//   - On rsp_ready[gnt]: last_grant<=gnt; next state IDLE.
//   - rsp_ready on non-granted bits is ignored. rsp_result holds until the next capture.
//  req_ready is 0 in EXEC and RESP; no new accept is possible while busy.
//  Timing (accept edge = T)
//   - rsp_valid is first high in the cycle after edge T+EXEC_CYCLES.
//   - Peak throughput = 1 op per EXEC_CYCLES+2 cycles.
//  Fairness: a requester with req_valid held high is granted within NREQ ops.
//  add_srcA/B hold their last operands in IDLE; they are 0 after reset.
// CONFIGURATION
//  FPADD_ARB_PERF_EN defined
//   - perf_ops is a 32-bit counter, +1 on each rsp handshake.
//   - Wraps 32'hFFFFFFFF->0. Cleared by reset.
//  FPADD_ARB_PERF_EN undefined
//   - perf_ops tied to 32'h0; no counter flops.
// TESTING  (stub adder: add_result = add_srcA + add_srcB as integers)
//  1. reset=0 for 3 cycles, req_valid=2'b11
//     -> req_ready=0, rsp_valid=0, busy=0, add_srcA=0, rsp_result=0.
//  2. req0 srcA=64'h3FF0000000000000, srcB=64'h4000000000000000, EXEC_CYCLES=1, rsp_ready=1
//     -> accepted at edge T; rsp_valid=2'b01 in the cycle after edge T+1;
//        rsp_result=64'h7FF0000000000000.
//  3. req_valid=2'b11 held, rsp_ready=2'b11
//     -> grant order 0,1,0,1; perf_ops=4 after 4 responses (PERF_EN).
//  4. rsp_ready=0 for 5 cycles in RESP
//     -> rsp_valid and rsp_result stable; req_ready=0; resumes 1 cycle after rsp_ready=1.
//  5. reset=0 for 1 cycle during EXEC (EXEC_CYCLES=4)
//     -> no rsp_valid; IDLE next cycle; with 2'b11 valid, req0 is granted.
//  6. Build without FPADD_ARB_PERF_EN, run 3 ops
//     -> perf_ops=0 throughout; results identical to the PERF_EN build.

Source files
------------

// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter: round-robin sequencer that shares one combinational
// double_adder among NREQ requesters. It accepts one operand pair at a time,
// holds it on the adder for EXEC_CYCLES cycles (a multicycle path), registers
// the sum and hands it back to the requester that won the grant.
//
// Optional feature: define FPADD_ARB_PERF_EN to build a 32-bit completed-op
// counter on perf_ops. Without it, perf_ops is tied to zero and no counter
// flops exist.

module fpadd_arbiter #(
  parameter int NREQ        = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,       // synchronous, active-low
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_srcA,
  input  logic [NREQ*64-1:0]   req_srcB,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_result,
  output logic [63:0]          add_srcA,
  output logic [63:0]          add_srcB,
  input  logic [63:0]          add_result,
  output logic                 busy,
  output logic [31:0]          perf_ops
);

  // Hold count below 1 is meaningless; treat it as a single-cycle hold.
  localparam int EXEC_EFF = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int CW       = $clog2(EXEC_EFF + 1);
  localparam int GW       = $clog2(NREQ);

  localparam logic [CW-1:0] CNT_LOAD  = CW'(EXEC_EFF - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     opa_q, opa_d;
  logic [63:0]     opb_q, opb_d;
  logic [63:0]     res_q, res_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Round-robin winner search results.
  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic [GW:0]     cand;

  // Rotating-priority search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) begin
        cand = cand - (GW+1)'(NREQ);
      end
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  // Next-state and handshake outputs; handshakes are suppressed while reset
  // is asserted so a dropped op can never be answered or a new one accepted.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;

    case (state_q)
      IDLE: begin
        if (reset && win_found) begin
          req_ready[win_idx] = 1'b1;
          opa_d   = req_srcA[win_idx*64 +: 64];
          opb_d   = req_srcB[win_idx*64 +: 64];
          gnt_d   = win_idx;
          cnt_d   = CNT_LOAD;
          state_d = EXEC;
        end
      end

      EXEC: begin
        // Operands sit on the adder; capture once the hold time has elapsed.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          res_d   = add_result;
          state_d = RESP;
        end
      end

      RESP: begin
        rsp_valid[gnt_q] = reset;
        if (reset && rsp_ready[gnt_q]) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and result registers; cleared on reset so the adder inputs and
  // the response bus read zero until the first operation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
    end
  end

  assign add_srcA   = opa_q;
  assign add_srcB   = opb_q;
  assign rsp_result = res_q;
  assign busy       = (state_q != IDLE);

`ifdef FPADD_ARB_PERF_EN
  logic        rsp_hs;
  logic [31:0] perf_q, perf_d;

  assign rsp_hs = (state_q == RESP) && reset && rsp_ready[gnt_q];
  assign perf_d = rsp_hs ? (perf_q + 32'd1) : perf_q;

  // Completed-operation counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_ops = perf_q;
`else
  assign perf_ops = 32'h0;
`endif

endmodule
